id_check_scheduler: RTL and testbench
=====================================

Name: id_check_scheduler

Overview:
- Shares one ID-check datapath (24-bit comparator plus clocked grant/deny monitor) among N_REQ requesters.
- Holds the configured fixed ID and arbitrates round-robin among pending requests.
- Drives the selected dynamic ID into the check path and samples the verdict after a fixed latency.
- Returns a per-request response and raises an interrupt on denial.
- Sits between bus-side requesters and the wrapper logic instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- RESULT_WAIT, 2, cycles from driving chk_id_dynamic to sampling the verdict (1..15).
- LOCK_THRESH, 3, consecutive denials before lockout (LOCKOUT_EN only).
- LOCK_CYCLES, 1024, lockout duration in cycles (LOCKOUT_EN only).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  write strobe for the fixed ID.
- cfg_id  in  32  fixed ID value.
- req_valid  in  N_REQ  per-requester request.
- req_id  in  32*N_REQ  per-requester dynamic ID; slot i = bits [32i+31:32i].
- req_ready  out  N_REQ  one-hot acceptance pulse.
- chk_id_fixed  out  32  fixed ID to the check path.
- chk_id_dynamic  out  32  selected dynamic ID to the check path.
- chk_granted  in  1  verdict: grant.
- chk_denied  in  1  verdict: deny.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_idx  out  3  requester index of the response.
- rsp_granted  out  1  1 = granted, 0 = denied.
- rsp_err  out  1  verdict was invalid (neither or both asserted).
- busy  out  1  FSM not in IDLE.
- irq  out  1  sticky denial interrupt.
- irq_clr  in  1  clears irq.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; chk_id_fixed = 0, chk_id_dynamic = 0.
  - FSM = IDLE; round-robin pointer = 0.
- cfg_we:
  - Writes the fixed-ID register on any cycle; chk_id_fixed follows it the next cycle.
  - A write while busy=1 takes effect on the next check only. The in-flight check keeps the latched value.
- FSM:
  - IDLE: if any eligible req_valid, pick the first set bit at or after the pointer (wrapping). Then:
    - pulse req_ready[sel] for one cycle;
    - latch req_id[sel] into chk_id_dynamic;
    - latch sel;
    - go to WAIT with counter = RESULT_WAIT-1.
  - WAIT: decrement the counter. At 0, sample chk_granted/chk_denied and go to RESPOND.
  - RESPOND: assert for one cycle:
    - rsp_valid = 1, rsp_idx = sel;
    - rsp_granted = chk_granted & ~chk_denied;
    - rsp_err = (chk_granted == chk_denied).
    Then pointer = sel+1 mod N_REQ, return to IDLE.
- Timing:
  - Latency from req_ready to rsp_valid = RESULT_WAIT+1 cycles.
  - Minimum spacing between accepts = RESULT_WAIT+2 cycles.
- Handshake:
  - A requester holds req_valid and req_id stable until it sees req_ready.
  - Dropping req_valid before acceptance withdraws the request with no side effect.
- chk_id_dynamic holds the last value between checks.
- irq:
  - Set on a RESPOND cycle with rsp_granted = 0 (includes rsp_err).
  - Cleared by irq_clr. If set and clear occur in the same cycle, set wins.
- Mid-operation reset returns immediately to the reset state. No response is issued for the in-flight request.
- Out-of-range indices (≥ N_REQ) are never selected.

Optional Feature:
- Macro: ID_CHECK_LOCKOUT_EN.
- When defined:
  - Each requester has a saturating 2-bit-or-wider consecutive-deny counter.
  - A grant resets the counter to 0.
  - When the counter reaches LOCK_THRESH, the requester is ineligible for arbitration for LOCK_CYCLES cycles. It is then re-enabled and its counter cleared.
  - Locked requesters' req_valid is ignored (no req_ready).
  - An extra output, lock_status [N_REQ], reflects lock state and is 0 at reset.
- When undefined: no counters, all requesters always eligible, no lock_status port.

Test Plan:
- Single grant: cfg_id=0x00ABCDEF, req_valid=0001, req_id0=0xFFABCDEF.
  - req_ready=0001.
  - Check path returns granted.
  - 3 cycles later (RESULT_WAIT=2): rsp_valid=1, rsp_idx=0, rsp_granted=1, irq=0.
- Denial and irq: req_id1=0x00000001 with verdict denied.
  - rsp_idx=1, rsp_granted=0, irq=1 until irq_clr.
  - irq_clr on the same cycle as a new denial leaves irq=1.
- Round-robin: all four req_valid held high.
  - Accept order 0,1,2,3,0.
  - Accepts spaced exactly 4 cycles apart.
- Invalid verdict: force chk_granted=chk_denied=1 at the sample cycle.
  - rsp_err=1, rsp_granted=0, irq=1.
- Reset mid-check: assert rst during WAIT.
  - Outputs 0 asynchronously; no rsp_valid afterwards.
  - Pointer=0 on the next request.
- Lockout (ID_CHECK_LOCKOUT_EN, LOCK_CYCLES=16): requester 2 denied 3 times.
  - lock_status[2]=1; its req_valid is ignored for 16 cycles, then accepted again.

Source files
------------

// File: rtl/id_check_scheduler.sv
// Round-robin scheduler sharing one ID-check path among N_REQ requesters.
// Optional build macro ID_CHECK_LOCKOUT_EN adds per-requester deny lockout and the lock_status port.
module id_check_scheduler #(
  parameter int N_REQ       = 4,
  parameter int RESULT_WAIT = 2,
  parameter int LOCK_THRESH = 3,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [31:0]        cfg_id,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [32*N_REQ-1:0] req_id,
  output logic [N_REQ-1:0]   req_ready,
  output logic [31:0]        chk_id_fixed,
  output logic [31:0]        chk_id_dynamic,
  input  logic               chk_granted,
  input  logic               chk_denied,
  output logic               rsp_valid,
  output logic [2:0]         rsp_idx,
  output logic               rsp_granted,
  output logic               rsp_err,
  output logic               busy,
  output logic               irq,
  input  logic               irq_clr
`ifdef ID_CHECK_LOCKOUT_EN
  ,
  output logic [N_REQ-1:0]   lock_status
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic [2:0]       ptr, sel, pick;
  logic             found;
  logic [N_REQ-1:0] elig;
  logic             v_gr, v_dn, grant_ok;
  logic [31:0]      fixed_reg;

  assign grant_ok = v_gr & ~v_dn;
  assign busy     = (state != IDLE);

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int unsigned k = 0; k < 32'(N_REQ); k++) begin
      j = (32'(ptr) + k) % 32'(N_REQ);
      if (!found && elig[j]) begin
        found = 1'b1;
        pick  = 3'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready      <= '0;
      chk_id_fixed   <= '0;
      chk_id_dynamic <= '0;
      fixed_reg      <= '0;
      rsp_valid      <= 1'b0;
      rsp_idx        <= '0;
      rsp_granted    <= 1'b0;
      rsp_err        <= 1'b0;
      irq            <= 1'b0;
      cnt            <= '0;
      ptr            <= '0;
      sel            <= '0;
      v_gr           <= 1'b0;
      v_dn           <= 1'b0;
    end else begin
      req_ready   <= '0;
      rsp_valid   <= 1'b0;
      rsp_granted <= 1'b0;
      rsp_err     <= 1'b0;
      if (cfg_we) fixed_reg <= cfg_id;
      // Fixed ID is frozen while a check is in flight; a same-cycle write counts at accept.
      if (state == IDLE) chk_id_fixed <= cfg_we ? cfg_id : fixed_reg;
      unique case (state)
        IDLE: if (found) begin
          req_ready      <= N_REQ'(1) << pick;
          chk_id_dynamic <= req_id[32*pick +: 32];
          sel            <= pick;
          cnt            <= 4'(RESULT_WAIT - 1);
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == '0) begin
            v_gr <= chk_granted;
            v_dn <= chk_denied;
          end
        end
        RESPOND: begin
          rsp_valid   <= 1'b1;
          rsp_idx     <= sel;
          rsp_granted <= grant_ok;
          rsp_err     <= (v_gr == v_dn);
          ptr         <= (sel == 3'(N_REQ - 1)) ? '0 : sel + 3'd1;
        end
        default: ;
      endcase
      if (state == RESPOND && !grant_ok) irq <= 1'b1;
      else if (irq_clr)                  irq <= 1'b0;
    end
  end

`ifdef ID_CHECK_LOCKOUT_EN
  localparam int DW = ($clog2(LOCK_THRESH + 1) < 2) ? 2 : $clog2(LOCK_THRESH + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  logic [DW-1:0]    deny_cnt [N_REQ];
  logic [TW-1:0]    lock_tmr [N_REQ];
  logic [N_REQ-1:0] locked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= '0;
      for (int unsigned i = 0; i < 32'(N_REQ); i++) begin
        deny_cnt[i] <= '0;
        lock_tmr[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 32'(N_REQ); i++) begin
        if (locked[i]) begin
          if (lock_tmr[i] == TW'(1)) begin
            locked[i]   <= 1'b0;
            deny_cnt[i] <= '0;
            lock_tmr[i] <= '0;
          end else begin
            lock_tmr[i] <= lock_tmr[i] - TW'(1);
          end
        end else if (state == RESPOND && sel == 3'(i)) begin
          if (grant_ok) begin
            deny_cnt[i] <= '0;
          end else if (deny_cnt[i] >= DW'(LOCK_THRESH - 1)) begin
            deny_cnt[i] <= DW'(LOCK_THRESH);
            locked[i]   <= 1'b1;
            lock_tmr[i] <= TW'(LOCK_CYCLES);
          end else begin
            deny_cnt[i] <= deny_cnt[i] + DW'(1);
          end
        end
      end
    end
  end

  assign elig        = req_valid & ~locked;
  assign lock_status = locked;
`else
  localparam int lock_cfg_unused = LOCK_THRESH + LOCK_CYCLES;
  assign elig = req_valid;
`endif

endmodule

// File: tb/tb_id_check_scheduler.sv
// Directed, table-driven bench for id_check_scheduler (N_REQ=4, RESULT_WAIT=2, LOCK_CYCLES=16).
module tb_id_check_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [31:0]  cfg_id;
  logic [3:0]   req_valid;
  logic [127:0] req_id;
  logic [3:0]   req_ready;
  logic [31:0]  chk_id_fixed, chk_id_dynamic;
  logic         chk_granted, chk_denied;
  logic         rsp_valid, rsp_granted, rsp_err, busy, irq, irq_clr;
  logic [2:0]   rsp_idx;
`ifdef ID_CHECK_LOCKOUT_EN
  logic [3:0]   lock_status;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  id_check_scheduler #(
    .N_REQ(4), .RESULT_WAIT(2), .LOCK_THRESH(3), .LOCK_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_id(cfg_id),
    .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
    .chk_id_fixed(chk_id_fixed), .chk_id_dynamic(chk_id_dynamic),
    .chk_granted(chk_granted), .chk_denied(chk_denied),
    .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_granted(rsp_granted),
    .rsp_err(rsp_err), .busy(busy), .irq(irq), .irq_clr(irq_clr)
`ifdef ID_CHECK_LOCKOUT_EN
    , .lock_status(lock_status)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] id;
    logic        gr, dn, clr;
    logic [2:0]  e_idx;
    logic        e_gr, e_err, e_irq;
  } vec_t;

  vec_t vecs [6];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_ids(input logic [31:0] base);
    for (int i = 0; i < 4; i++) req_id[32*i +: 32] = base + 32'(i);
  endtask

  task automatic wait_ready(output bit got);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (req_ready != 4'b0) begin
        got = 1'b1;
        break;
      end
    end
    check("ready_seen", 32'(got), 32'd1);
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    bit got;
    if (v.clr) begin
      irq_clr = 1'b1;
      cyc();
      irq_clr = 1'b0;
      check({tag, "_irq_cleared"}, 32'(irq), 32'd0);
    end
    chk_granted = v.gr;
    chk_denied  = v.dn;
    set_ids(v.id);
    req_valid = v.valid;
    wait_ready(got);
    req_valid = 4'b0;
    check({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << v.e_idx));
    check({tag, "_dyn_id"}, chk_id_dynamic, v.id + 32'(v.e_idx));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc();
    check({tag, "_early1"}, 32'(rsp_valid), 32'd0);
    cyc();
    check({tag, "_early2"}, 32'(rsp_valid), 32'd0);
    cyc();
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_idx"}, 32'(rsp_idx), 32'(v.e_idx));
    check({tag, "_rsp_granted"}, 32'(rsp_granted), 32'(v.e_gr));
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'(v.e_err));
    check({tag, "_irq"}, 32'(irq), 32'(v.e_irq));
    cyc();
    check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    bit          got;
    int          acc_idx [5];
    int          acc_t   [5];
    int          n_acc;
    int          stray;

    vecs[0] = '{4'b0001, 32'hFFABCDEF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'b0010, 32'h00000000, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{4'b1001, 32'h11110000, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'b1111, 32'h22220000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{4'b0001, 32'h33330000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{4'b0101, 32'h44440000, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; cfg_we = 1'b0; cfg_id = '0; req_valid = '0; req_id = '0;
    chk_granted = 1'b0; chk_denied = 1'b0; irq_clr = 1'b0;
    cyc(); cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_fixed", chk_id_fixed, 32'd0);
    check("rst_dyn", chk_id_dynamic, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    cyc();

    cfg_we = 1'b1; cfg_id = 32'h00ABCDEF;
    cyc();
    cfg_we = 1'b0;
    check("cfg_fixed", chk_id_fixed, 32'h00ABCDEF);

    for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Busy-time config write plus irq_clr colliding with a new denial.
    chk_granted = 1'b0; chk_denied = 1'b1;
    set_ids(32'h55550000);
    req_valid = 4'b0010;
    wait_ready(got);
    req_valid = 4'b0;
    check("hold_ready", 32'(req_ready), 32'b0010);
    cfg_we = 1'b1; cfg_id = 32'h12345678;
    cyc();
    cfg_we = 1'b0;
    check("hold_fixed_busy", chk_id_fixed, 32'h00ABCDEF);
    cyc();
    irq_clr = 1'b1;
    cyc();
    check("clr_vs_set_rsp", 32'(rsp_valid), 32'd1);
    check("clr_vs_set_irq", 32'(irq), 32'd1);
    cyc();
    irq_clr = 1'b0;
    check("clr_after", 32'(irq), 32'd0);
    check("fixed_after_idle", chk_id_fixed, 32'h12345678);

    // Reset during WAIT: ptr is 2 here, so requester 3 is in flight.
    chk_granted = 1'b1; chk_denied = 1'b0;
    set_ids(32'hA5A5A5A0);
    req_valid = 4'b1000;
    wait_ready(got);
    req_valid = 4'b0;
    check("mid_dyn", chk_id_dynamic, 32'hA5A5A5A3);
    cyc();
    #2 rst = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_dyn_zero", chk_id_dynamic, 32'd0);
    check("mid_fixed_zero", chk_id_fixed, 32'd0);
    check("mid_ready_zero", 32'(req_ready), 32'd0);
    cyc();
    rst = 1'b0;
    stray = 0;
    for (int n = 0; n < 6; n++) begin
      cyc();
      if (rsp_valid) stray++;
    end
    check("mid_no_rsp", 32'(stray), 32'd0);

    // Round-robin with all requesters held high from pointer 0.
    req_valid = 4'b1111;
    n_acc = 0;
    for (int n = 0; n < 40 && n_acc < 5; n++) begin
      cyc();
      if (req_ready != 4'b0) begin
        acc_t[n_acc] = n;
        acc_idx[n_acc] = 0;
        for (int b = 0; b < 4; b++) if (req_ready[b]) acc_idx[n_acc] = b;
        n_acc++;
      end
    end
    req_valid = 4'b0;
    check("rr_count", 32'(n_acc), 32'd5);
    for (int k = 0; k < n_acc; k++) begin
      check($sformatf("rr_order%0d", k), 32'(acc_idx[k]), 32'(k % 4));
      if (k > 0) check($sformatf("rr_gap%0d", k), 32'(acc_t[k] - acc_t[k-1]), 32'd4);
    end
    for (int n = 0; n < 6; n++) cyc();

`ifdef ID_CHECK_LOCKOUT_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++)
      do_txn('{4'b0100, 32'h66660000, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1},
             $sformatf("lock%0d", k));
    check("lock_set", 32'(lock_status), 32'b0100);
    chk_granted = 1'b1; chk_denied = 1'b0;
    req_valid = 4'b0100;
    stray = 0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      if (req_ready != 4'b0) stray++;
    end
    check("lock_ignored", 32'(stray), 32'd0);
    wait_ready(got);
    req_valid = 4'b0;
    check("lock_reaccept", 32'(req_ready), 32'b0100);
    check("lock_released", 32'(lock_status), 32'd0);
    for (int n = 0; n < 6; n++) cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
